exe_unit_apb_master: RTL

APB initiator that drives the execution-unit slave from a simple local request/response handshake. It accepts one operation (argA, argB, oper) from the local requester and writes the three operands to the slave's register map as three APB writes. It then waits for the unit's registered result and reads back result and status with one APB read. It sits between the test/control logic and the APB-wrapped execution unit, as the issuing end of that bus.

---
 rtl/exe_unit_apb_master.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/exe_unit_apb_master.sv
// -----------------------------------------------------------------------------
// exe_unit_apb_master
//
// APB initiator for the execution-unit slave. A local request carrying
// (argA, argB, oper) is turned into three APB writes (ARGA @0x0, ARGB @0x4,
// OPER @0x8), a short idle gap while the unit registers its result, and one
// APB read of RESULT @0xC. The read data is split into result/status and
// handed back through a valid/ready response port. One operation at a time.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   defined   - an ACCESS phase lasting TIMEOUT cycles without PREADY aborts
//               the operation with an error response.
//   undefined - ACCESS waits for PREADY indefinitely.
//
// Ports:
//   i_clk, i_rsn                  clock (rising edge), async active-low reset
//   i_req_valid / o_req_ready     request handshake
//   i_argA, i_argB, i_oper        operands, sampled at acceptance
//   o_rsp_valid / i_rsp_ready     response handshake
//   o_result, o_status, o_rsp_err response payload
//   o_psel, o_penable, o_pwrite,
//   o_paddr, o_pwdata             APB request side (all registered)
//   i_prdata, i_pready, i_pslverr APB completion side
// -----------------------------------------------------------------------------
module exe_unit_apb_master #(
   parameter int BITS        = 4,
   parameter int N           = 2,
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 1,
   parameter int TIMEOUT     = 16
) (
   input  logic              i_clk,
   input  logic              i_rsn,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [BITS-1:0]   i_argA,
   input  logic [BITS-1:0]   i_argB,
   input  logic [N-1:0]      i_oper,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [BITS-1:0]   o_result,
   output logic [3:0]        o_status,
   output logic              o_rsp_err,
   output logic              o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [DATA_W-1:0] o_pwdata,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready,
   input  logic              i_pslverr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WAIT,
      S_RESP
   } state_t;

   localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   // Status word reported for any failed transfer: only the error bit set.
   localparam logic [3:0] ERR_STATUS = 4'b1000;

   // Reject parameter sets for which the RESULT register layout cannot fit.
   if (BITS + 4 > DATA_W || WAIT_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
      $error("exe_unit_apb_master: illegal parameter combination");
   end

   state_t          state, next_state;
   logic [1:0]      phase, phase_d;
   logic [BITS-1:0] arg_b;
   logic [N-1:0]    oper_q;
   logic [WCW-1:0]  wait_cnt;

   logic              accept, wait_done, xfer_ok;
   logic              psel_d, penable_d, pwrite_d, req_ready_d, rsp_valid_d, rsp_err_d;
   logic [ADDR_W-1:0] paddr_d;
   logic [DATA_W-1:0] pwdata_d;
   logic [BITS-1:0]   result_d;
   logic [3:0]        status_d;
   logic              timeout_hit;

   // Registers are word-spaced: phase p lives at byte address 4*p.
   function automatic logic [ADDR_W-1:0] phase_addr(input logic [1:0] p);
      logic [ADDR_W-1:0] a;
      a      = '0;
      a[3:2] = p;
      return a;
   endfunction

   // The ready flag is registered, so acceptance needs both the flag and the
   // request; this is also what keeps the first post-reset cycle idle.
   assign accept    = (state == S_IDLE) && o_req_ready && i_req_valid;
   assign wait_done = (wait_cnt == WCW'(WAIT_CYCLES - 1));
   assign xfer_ok   = i_pready && !i_pslverr;

`ifdef APB_TIMEOUT_EN
   localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TOW-1:0] to_cnt;

   assign timeout_hit = (state == S_ACCESS) && !i_pready && (to_cnt == TOW'(TIMEOUT - 1));

   // Counts ACCESS cycles of the current transfer; any other state restarts it.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn)                to_cnt <= '0;
      else if (state == S_ACCESS) to_cnt <= to_cnt + 1'b1;
      else                       to_cnt <= '0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register together with every output register, so each output is
   // a flop whose next value is worked out by the output logic below.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         state       <= S_IDLE;
         o_req_ready <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_result    <= '0;
         o_status    <= '0;
         o_rsp_err   <= 1'b0;
         o_psel      <= 1'b0;
         o_penable   <= 1'b0;
         o_pwrite    <= 1'b0;
         o_paddr     <= '0;
         o_pwdata    <= '0;
      end else begin
         state       <= next_state;
         o_req_ready <= req_ready_d;
         o_rsp_valid <= rsp_valid_d;
         o_result    <= result_d;
         o_status    <= status_d;
         o_rsp_err   <= rsp_err_d;
         o_psel      <= psel_d;
         o_penable   <= penable_d;
         o_pwrite    <= pwrite_d;
         o_paddr     <= paddr_d;
         o_pwdata    <= pwdata_d;
      end
   end

   // Operand capture, transfer index and the post-OPER idle counter.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         phase    <= '0;
         arg_b    <= '0;
         oper_q   <= '0;
         wait_cnt <= '0;
      end else begin
         phase <= phase_d;
         if (accept) begin
            arg_b  <= i_argB;
            oper_q <= i_oper;
         end
         if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
         else                 wait_cnt <= '0;
      end
   end

   // Sequencing: three writes, an idle gap, one read; a slave error or a
   // timeout short-circuits straight to the response.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (accept) next_state = S_SETUP;
         S_SETUP:  next_state = S_ACCESS;
         S_ACCESS: begin
            if (i_pready) begin
               if (i_pslverr || phase == 2'd3) next_state = S_RESP;
               else if (phase == 2'd2)         next_state = S_WAIT;
               else                            next_state = S_SETUP;
            end else if (timeout_hit) begin
               next_state = S_RESP;
            end
         end
         S_WAIT:   if (wait_done) next_state = S_SETUP;
         S_RESP:   if (i_rsp_ready) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Next values of the output registers. Address and write data are only
   // reloaded when a new transfer enters SETUP; otherwise they hold, which
   // keeps them stable through ACCESS and parked between transfers.
   always_comb begin
      phase_d     = phase;
      req_ready_d = (next_state == S_IDLE);
      rsp_valid_d = (next_state == S_RESP);
      psel_d      = (next_state == S_SETUP) || (next_state == S_ACCESS);
      penable_d   = (next_state == S_ACCESS);
      pwrite_d    = o_pwrite;
      paddr_d     = o_paddr;
      pwdata_d    = o_pwdata;
      result_d    = o_result;
      status_d    = o_status;
      rsp_err_d   = o_rsp_err;

      if (accept)
         phase_d = 2'd0;
      else if (state == S_ACCESS && xfer_ok && phase < 2'd2)
         phase_d = phase + 2'd1;
      else if (state == S_WAIT && wait_done)
         phase_d = 2'd3;

      // ARGA is driven straight from the request port because the SETUP of
      // phase 0 is loaded on the same edge that accepts the request.
      if (state != S_SETUP && next_state == S_SETUP) begin
         paddr_d  = phase_addr(phase_d);
         pwrite_d = (phase_d != 2'd3);
         case (phase_d)
            2'd0:    pwdata_d = DATA_W'(i_argA);
            2'd1:    pwdata_d = DATA_W'(arg_b);
            2'd2:    pwdata_d = DATA_W'(oper_q);
            default: pwdata_d = o_pwdata;
         endcase
      end

      if (state == S_ACCESS && next_state == S_RESP) begin
         if (xfer_ok) begin
            result_d  = i_prdata[BITS-1:0];
            status_d  = i_prdata[BITS+3:BITS];
            rsp_err_d = 1'b0;
         end else begin
            result_d  = '0;
            status_d  = ERR_STATUS;
            rsp_err_d = 1'b1;
         end
      end
   end

endmodule
